// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU data port and the debug/loader port.
// One access per cycle reaches the memory. Arbitration is round-robin, and
// the debug port can take a bounded locked burst. Read data returns one cycle
// after the grant and is tagged to the port that issued the read.
module dm_arbiter #(
    parameter int AW       = 10,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [3:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_lock,
    input  logic [3:0]    dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wea,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
);

    localparam int            CW         = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CPU_OWN    = 2'd1,
        DBG_OWN    = 2'd2,
        DBG_LOCKED = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          last_dbg_r;       // 1: debug won the most recent granted cycle
    logic          last_dbg_nxt_s;
    logic [CW-1:0] lock_cnt_r;       // locked grant cycles consumed in this burst
    logic [CW-1:0] lock_cnt_nxt_s;
    logic [CW-1:0] lock_inc_s;
    logic          rearm_blk_r;      // lock may not be re-entered until dbg_lock drops
    logic          rearm_blk_nxt_s;
    logic          cpu_gnt_s;
    logic          dbg_gnt_s;
    logic          cpu_rd_pend_r;
    logic          dbg_rd_pend_r;
    logic [AW-1:0] addr_hold_r;
    logic [31:0]   din_hold_r;

    // Grant decision and next-state logic from current state and requests.
    always_comb begin
        cpu_gnt_s       = 1'b0;
        dbg_gnt_s       = 1'b0;
        state_nxt_s     = state_r;
        last_dbg_nxt_s  = last_dbg_r;
        lock_cnt_nxt_s  = lock_cnt_r;
        rearm_blk_nxt_s = rearm_blk_r;
        if (lock_cnt_r < LOCK_MAX_C) begin
            lock_inc_s = lock_cnt_r + CNT_ONE;
        end else begin
            lock_inc_s = LOCK_MAX_C;
        end
        if (reset) begin
            // No grant while reset is applied, so nothing reaches the memory.
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                DBG_LOCKED: begin
                    // Debug owns every cycle of the burst; an empty cycle still counts.
                    dbg_gnt_s      = dbg_req;
                    last_dbg_nxt_s = 1'b1;
                    if (!dbg_lock) begin
                        state_nxt_s     = IDLE;
                        lock_cnt_nxt_s  = CNT_ZERO;
                        rearm_blk_nxt_s = 1'b0;
                    end else if (lock_inc_s >= LOCK_MAX_C) begin
                        // Budget exhausted while lock still held: force the CPU a turn.
                        state_nxt_s     = IDLE;
                        lock_cnt_nxt_s  = CNT_ZERO;
                        rearm_blk_nxt_s = 1'b1;
                    end else begin
                        lock_cnt_nxt_s  = lock_inc_s;
                    end
                end
                IDLE, CPU_OWN, DBG_OWN: begin
                    if (cpu_req && dbg_req) begin
                        if (last_dbg_r) begin
                            cpu_gnt_s = 1'b1;
                        end else begin
                            dbg_gnt_s = 1'b1;
                        end
                    end else begin
                        cpu_gnt_s = cpu_req;
                        dbg_gnt_s = dbg_req;
                    end
                    if (!dbg_lock) begin
                        rearm_blk_nxt_s = 1'b0;
                    end else begin
                        rearm_blk_nxt_s = rearm_blk_r;
                    end
                    if (cpu_gnt_s) begin
                        state_nxt_s    = CPU_OWN;
                        last_dbg_nxt_s = 1'b0;
                    end else if (dbg_gnt_s) begin
                        last_dbg_nxt_s = 1'b1;
                        if (dbg_lock && !rearm_blk_r) begin
                            // The entering grant is the first locked cycle.
                            if (LOCK_MAX_C > CNT_ONE) begin
                                state_nxt_s    = DBG_LOCKED;
                                lock_cnt_nxt_s = CNT_ONE;
                            end else begin
                                state_nxt_s     = IDLE;
                                lock_cnt_nxt_s  = CNT_ZERO;
                                rearm_blk_nxt_s = 1'b1;
                            end
                        end else begin
                            state_nxt_s = DBG_OWN;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s    = IDLE;
                    lock_cnt_nxt_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            last_dbg_r  <= 1'b1;
            lock_cnt_r  <= CNT_ZERO;
            rearm_blk_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            last_dbg_r  <= last_dbg_nxt_s;
            lock_cnt_r  <= lock_cnt_nxt_s;
            rearm_blk_r <= rearm_blk_nxt_s;
        end
    end

    // Memory port mux: granted port drives the memory, otherwise hold address/data.
    always_comb begin
        mem_wea  = 4'b0000;
        mem_addr = addr_hold_r;
        mem_din  = din_hold_r;
        if (reset) begin
            mem_addr = {AW{1'b0}};
            mem_din  = 32'h0000_0000;
        end else if (cpu_gnt_s) begin
            mem_addr = cpu_addr;
            mem_wea  = cpu_we;
            mem_din  = cpu_wdata;
        end else if (dbg_gnt_s) begin
            mem_addr = dbg_addr;
            mem_wea  = dbg_we;
            mem_din  = dbg_wdata;
        end else begin
            mem_wea  = 4'b0000;
        end
    end

    // Remember the last driven address/data and which port has a read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_r   <= {AW{1'b0}};
            din_hold_r    <= 32'h0000_0000;
            cpu_rd_pend_r <= 1'b0;
            dbg_rd_pend_r <= 1'b0;
        end else begin
            addr_hold_r   <= mem_addr;
            din_hold_r    <= mem_din;
            cpu_rd_pend_r <= cpu_gnt_s & (cpu_we == 4'b0000);
            dbg_rd_pend_r <= dbg_gnt_s & (dbg_we == 4'b0000);
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt_s & ~reset;
    assign dbg_gnt    = dbg_req & dbg_gnt_s;
    // A read in flight when reset arrives must not report valid data.
    assign cpu_rvalid = cpu_rd_pend_r & ~reset;
    assign dbg_rvalid = dbg_rd_pend_r & ~reset;
    assign cpu_rdata  = mem_dout;
    assign dbg_rdata  = mem_dout;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter: hand-computed expectations per cycle.
module tb_dm_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          dbg_req;
    logic          dbg_lock;
    logic [3:0]    dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [31:0]   dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wea;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    int tests_run    = 0;
    int tests_failed = 0;

    dm_arbiter #(.AW(AW), .LOCK_MAX(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_lock   (dbg_lock),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_addr   (mem_addr),
        .mem_wea    (mem_wea),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_we    = 4'b0000;
        cpu_addr  = 10'h000;
        cpu_wdata = 32'h0000_0000;
        dbg_req   = 1'b0;
        dbg_lock  = 1'b0;
        dbg_we    = 4'b0000;
        dbg_addr  = 10'h000;
        dbg_wdata = 32'h0000_0000;
        mem_dout  = 32'h0000_0000;
    endtask

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset cycle with both ports trying to write: nothing may leak out.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 10'h155; cpu_wdata = 32'h1234_5678;
        dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 10'h0AA; dbg_wdata = 32'h8765_4321;
        #1;
        check_val("rst_mem_wea",  32'(mem_wea),    32'h0);
        check_val("rst_mem_addr", 32'(mem_addr),   32'h0);
        check_val("rst_mem_din",  mem_din,         32'h0);
        check_val("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        check_val("rst_dbg_gnt",  32'(dbg_gnt),    32'h0);
        check_val("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check_val("rst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        do_reset();

        // CPU read of 0x010, data returns next cycle.
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 10'h010;
        #1;
        check_val("rd_mem_addr", 32'(mem_addr), 32'h010);
        check_val("rd_stall",    32'(cpu_stall), 32'h0);
        check_val("rd_wea",      32'(mem_wea),  32'h0);
        @(negedge clk);
        cpu_req = 1'b0; mem_dout = 32'hDEAD_BEEF;
        #1;
        check_val("rd_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        check_val("rd_cpu_rdata",  cpu_rdata,       32'hDEAD_BEEF);
        check_val("rd_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        check_val("rd_addr_hold",  32'(mem_addr),   32'h010);
        @(negedge clk);
        #1;
        check_val("rd_rvalid_once", 32'(cpu_rvalid), 32'h0);

        // Both reading every cycle: CPU, DBG, CPU, DBG with in-order rvalids.
        do_reset();
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 10'h001;
        dbg_req = 1'b1; dbg_we = 4'b0000; dbg_addr = 10'h002;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_val($sformatf("rr_dbg_gnt_c%0d", c),   32'(dbg_gnt),   32'(c % 2));
            check_val($sformatf("rr_cpu_stall_c%0d", c), 32'(cpu_stall), 32'(c % 2));
            check_val($sformatf("rr_addr_c%0d", c),      32'(mem_addr),  (c % 2 == 0) ? 32'h001 : 32'h002);
            check_val($sformatf("rr_cpu_rv_c%0d", c),    32'(cpu_rvalid), (c % 2 == 1) ? 32'h1 : 32'h0);
            check_val($sformatf("rr_dbg_rv_c%0d", c),    32'(dbg_rvalid), (c == 2) ? 32'h1 : 32'h0);
            @(negedge clk);
        end

        // Debug partial write to the top word.
        do_reset();
        @(negedge clk);
        reset = 1'b0;
        dbg_req = 1'b1; dbg_we = 4'b0011; dbg_addr = 10'h3FF; dbg_wdata = 32'hCAFE_BABE;
        #1;
        check_val("wr_dbg_gnt", 32'(dbg_gnt),  32'h1);
        check_val("wr_wea",     32'(mem_wea),  32'h3);
        check_val("wr_addr",    32'(mem_addr), 32'h3FF);
        check_val("wr_din",     mem_din,       32'hCAFE_BABE);
        @(negedge clk);
        dbg_req = 1'b0; dbg_we = 4'b0000;
        #1;
        check_val("wr_wea_off",   32'(mem_wea),    32'h0);
        check_val("wr_no_rvalid", 32'(dbg_rvalid), 32'h0);
        check_val("wr_din_hold",  mem_din,         32'hCAFE_BABE);

        // Reset right after a CPU read grant kills the rvalid and the write.
        do_reset();
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 10'h020;
        #1;
        check_val("mr_grant", 32'(cpu_stall), 32'h0);
        @(negedge clk);
        reset = 1'b1; cpu_we = 4'hF;
        #1;
        check_val("mr_rvalid", 32'(cpu_rvalid), 32'h0);
        check_val("mr_wea",    32'(mem_wea),    32'h0);
        @(negedge clk);
        reset = 1'b0; cpu_we = 4'b0000; dbg_req = 1'b1;
        #1;
        check_val("mr_cpu_first", 32'(cpu_stall), 32'h0);
        check_val("mr_dbg_wait",  32'(dbg_gnt),   32'h0);
        check_val("mr_rvalid2",   32'(cpu_rvalid), 32'h0);

        // Lock held 20 cycles with both requesting: 16 locked debug grants.
        do_reset();
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            check_val($sformatf("lk_dbg_gnt_c%0d", c), 32'(dbg_gnt),
                      (((c >= 1) && (c <= 16)) || (c == 18)) ? 32'h1 : 32'h0);
            check_val($sformatf("lk_stall_c%0d", c), 32'(cpu_stall),
                      (((c >= 1) && (c <= 16)) || (c == 18)) ? 32'h1 : 32'h0);
            @(negedge clk);
        end

        // Lock dropped at cycle 5: CPU gets cycle 6, then round-robin.
        do_reset();
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int c = 0; c < 9; c++) begin
            dbg_lock = (c < 5) ? 1'b1 : 1'b0;
            #1;
            check_val($sformatf("ld_dbg_gnt_c%0d", c), 32'(dbg_gnt),
                      (((c >= 1) && (c <= 5)) || (c == 7)) ? 32'h1 : 32'h0);
            check_val($sformatf("ld_stall_c%0d", c), 32'(cpu_stall),
                      (((c >= 1) && (c <= 5)) || (c == 7)) ? 32'h1 : 32'h0);
            @(negedge clk);
        end

        // Locked cycle with debug idle: CPU still blocked, no memory write.
        do_reset();
        @(negedge clk);
        reset = 1'b0;
        dbg_req = 1'b1; dbg_lock = 1'b1;
        #1;
        check_val("li_enter", 32'(dbg_gnt), 32'h1);
        @(negedge clk);
        dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 10'h077;
        #1;
        check_val("li_stall", 32'(cpu_stall), 32'h1);
        check_val("li_wea",   32'(mem_wea),   32'h0);
        check_val("li_gnt",   32'(dbg_gnt),   32'h0);
        @(negedge clk);
        dbg_lock = 1'b0;
        #1;
        check_val("li_stall_exit", 32'(cpu_stall), 32'h1);
        @(negedge clk);
        #1;
        check_val("li_cpu_after", 32'(cpu_stall), 32'h0);
        check_val("li_cpu_wea",   32'(mem_wea),   32'hF);
        check_val("li_cpu_addr",  32'(mem_addr),  32'h077);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
